// File: rtl/alarm_timer_pkg.sv
// Shared encodings for the anti-theft alarm: interval selects (common with the
// time-parameter bank and alarm FSM) and the countdown timer state codes.
package alarm_timer_pkg;

  localparam logic [1:0] T_ARM_DELAY       = 2'b00;
  localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] T_ALARM_ON        = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running system-clock divider producing a combinational tick on the last
// cycle of each second and a registered one-cycle one_hz_enable after it.
module one_hz_divider #(
  parameter int CLK_DIV = 100000000,
  parameter int DIV_W   = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic one_hz_enable
);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // clear realigns the second boundary to the current edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      one_hz_enable <= 1'b0;
    end else begin
      one_hz_enable <= tick;
      if (clear || tick) div_cnt <= '0;
      else               div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// Whole-second countdown timer: latches a 4-bit duration on start_timer, counts
// it down on 1 Hz ticks and pulses expired for one cycle when it reaches zero.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_DIV = 100000000,
  parameter int DIV_W   = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [3:0] value,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       one_hz_enable
);

  timer_state_e state;
  logic         tick;

  one_hz_divider #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_one_hz_divider (
    .clock         (clock),
    .reset         (reset),
    .clear         (start_timer),
    .tick          (tick),
    .one_hz_enable (one_hz_enable)
  );

  // A start wins over everything, including the final cycle of an expiry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      expired   <= 1'b0;
      busy      <= 1'b0;
      remaining <= 4'd0;
    end else begin
      expired <= 1'b0;
      if (start_timer) begin
        remaining <= value;
        if (value != 4'd0) begin
          state <= COUNT;
          busy  <= 1'b1;
        end else begin
          state   <= EXPIRED;
          busy    <= 1'b0;
          expired <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          COUNT: begin
            if (tick) begin
              if (remaining > 4'd1) begin
                remaining <= remaining - 4'd1;
              end else begin
                remaining <= 4'd0;
                state     <= EXPIRED;
                busy      <= 1'b0;
                expired   <= 1'b1;
              end
            end
          end
          EXPIRED: state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer with CLK_DIV=4 against an elapsed-time
// reference model.
module tb_alarm_timer;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [3:0] value = 4'd0;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz_enable;

  int checks   = 0;
  int failures = 0;

  alarm_timer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .value         (value),
    .expired       (expired),
    .busy          (busy),
    .remaining     (remaining),
    .one_hz_enable (one_hz_enable)
  );

  always #5 clock = ~clock;

  // Reference model: time since the last start decides everything.
  int   m_since_clear;
  int   m_dur;
  int   m_elapsed;
  bit   m_active;
  bit   m_exp;
  bit   m_hz;
  int   m_rem;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_since_clear = 0;
      m_dur = 0; m_elapsed = 0; m_active = 0;
      m_exp = 0; m_hz = 0; m_rem = 0;
    end else begin
      m_since_clear = m_since_clear + 1;
      m_hz = (m_since_clear % CLK_DIV == 0);
      if (start_timer) begin
        m_since_clear = 0;
        m_dur = int'(value);
        m_elapsed = 0;
        m_rem = int'(value);
        m_active = (value != 4'd0);
        m_exp = (value == 4'd0);
      end else begin
        m_exp = 0;
        if (m_active) begin
          m_elapsed = m_elapsed + 1;
          m_rem = m_dur - m_elapsed / CLK_DIV;
          if (m_elapsed == m_dur * CLK_DIV) begin
            m_active = 0;
            m_exp = 1;
            m_rem = 0;
          end
        end
      end
    end
  end

  wire  [6:0] dut_v = {expired, busy, remaining, one_hz_enable};
  logic [6:0] mdl_v;
  always_comb mdl_v = {m_exp, m_active, 4'(m_rem), m_hz};

  // Drive inputs for one edge and return to the following falling edge.
  task automatic step(input logic s, input logic [3:0] v);
    start_timer = s;
    value = v;
    @(posedge clock);
    @(negedge clock);
    start_timer = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (dut_v !== 7'd0) begin
      failures++; $display("FAIL reset_init got=%b want=%b", dut_v, 7'd0);
    end
    @(negedge clock); reset = 1'b0;
    step(1'b1, 4'd5);
    for (int i = 0; i < 7; i++) step(1'b0, 4'd0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_v !== 7'd0) begin
      failures++; $display("FAIL reset_async got=%b want=%b", dut_v, 7'd0);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'd0);
      checks++;
      if (expired !== 1'b0 || dut_v !== mdl_v) begin
        failures++; $display("FAIL reset_no_expire cyc=%0d got=%b want=%b", i, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_basic_six();
    step(1'b1, 4'b0110);
    for (int i = 0; i <= 26; i++) begin
      if (i > 0) step(1'b0, 4'b0110);
      checks++;
      if (expired !== (i == 24) || busy !== (i < 24) ||
          remaining !== 4'(6 - ((i > 24 ? 24 : i) / 4)) || dut_v !== mdl_v) begin
        failures++;
        $display("FAIL basic6 i=%0d got exp=%b busy=%b rem=%0d want exp=%b busy=%b rem=%0d model=%b",
                 i, expired, busy, remaining, (i == 24), (i < 24), 6 - ((i > 24 ? 24 : i) / 4), mdl_v);
      end
    end
  endtask

  task automatic test_zero();
    step(1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0, 4'd9);
      checks++;
      if (expired !== (i == 0) || busy !== 1'b0 || remaining !== 4'd0 || dut_v !== mdl_v) begin
        failures++; $display("FAIL zero i=%0d got=%b want_exp=%b model=%b", i, dut_v, (i == 0), mdl_v);
      end
    end
  endtask

  task automatic test_value_change();
    step(1'b1, 4'b1111);
    for (int i = 1; i <= 62; i++) begin
      step(1'b0, (i >= 2) ? 4'b0010 : 4'b1111);
      checks++;
      if (expired !== (i == 60) || dut_v !== mdl_v) begin
        failures++; $display("FAIL value_change i=%0d got=%b model=%b want_exp=%b", i, dut_v, mdl_v, (i == 60));
      end
    end
  endtask

  task automatic test_restart();
    step(1'b1, 4'd8);
    for (int i = 1; i <= 36; i++) begin
      step(i == 10, (i == 10) ? 4'd2 : 4'd8);
      checks++;
      if (expired !== (i == 18) || dut_v !== mdl_v) begin
        failures++; $display("FAIL restart i=%0d got=%b model=%b want_exp=%b", i, dut_v, mdl_v, (i == 18));
      end
    end
  endtask

  task automatic test_start_during_expired();
    step(1'b1, 4'd3);
    for (int i = 1; i <= 12; i++) step(1'b0, 4'd0);
    checks++;
    if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
      failures++; $display("FAIL sde_pulse got=%b want exp=1 busy=0 rem=0", dut_v);
    end
    step(1'b1, 4'd4);
    checks++;
    if (expired !== 1'b0 || busy !== 1'b1 || remaining !== 4'd4 || dut_v !== mdl_v) begin
      failures++; $display("FAIL sde_restart got=%b want exp=0 busy=1 rem=4 model=%b", dut_v, mdl_v);
    end
    for (int i = 1; i <= 18; i++) begin
      step(1'b0, 4'd0);
      checks++;
      if (expired !== (i == 16) || dut_v !== mdl_v) begin
        failures++; $display("FAIL sde_count i=%0d got=%b model=%b", i, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic s;
      logic [3:0] v;
      s = ($urandom_range(0, 15) == 0);
      v = 4'($urandom_range(0, 15));
      if (i >= 300 && i < 304) s = 1'b1;
      step(s, v);
      checks++;
      if (dut_v !== mdl_v) begin
        failures++; $display("FAIL random i=%0d start=%b val=%0d got=%b model=%b", i, s, v, dut_v, mdl_v);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_six();
    test_zero();
    test_value_change();
    test_restart();
    test_start_during_expired();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
